// File: rtl/dual_ram_fifo_ctrl_pkg.sv
// Shared definitions for the dual-RAM FIFO controller.
// Contents:
//   DEPTH_LOG_DEFAULT : default log2 depth for the controller
//   ptr_t             : wide container type for pointer comparisons
//   ptr_full/ptr_empty: wrap-bit pointer comparisons, sized by a depth argument
// Pointers are compared inside a fixed-width container so that any instance
// depth can share these helpers. Callers zero-extend their own pointers.
package fifo_pkg;

  localparam int DEPTH_LOG_DEFAULT = 8;
  localparam int PTR_CONTAINER_W   = 16;

  typedef logic [PTR_CONTAINER_W-1:0] ptr_t;

  // Keeps only the DEPTH_LOG+1 bits that belong to a real pointer.
  function automatic ptr_t ptr_mask(input int unsigned dlog);
    return (ptr_t'(1) << (dlog + 1)) - ptr_t'(1);
  endfunction

  // Full: addresses match but the wrap bits differ.
  function automatic logic ptr_full(input ptr_t wr, input ptr_t rd, input int unsigned dlog);
    return ((wr ^ rd) & ptr_mask(dlog)) == (ptr_t'(1) << dlog);
  endfunction

  // Empty: both pointers are identical, including the wrap bit.
  function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd, input int unsigned dlog);
    return ((wr ^ rd) & ptr_mask(dlog)) == '0;
  endfunction

endpackage

// File: rtl/dual_ram_fifo_ctrl_if.sv
// Push/pop handshake bundle for the dual-RAM FIFO controller.
// Signals:
//   push_valid, push_data, push_ready : producer side
//   pop_valid,  pop_data,  pop_ready  : consumer side
// Modports:
//   master : the surrounding logic (drives push_*, pop_ready)
//   slave  : the FIFO controller
interface dual_ram_fifo_ctrl_if #(parameter int WIDTH = 8);

  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic             pop_ready;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );

endinterface

// File: rtl/dual_ram_fifo_ctrl_ptr.sv
// fifo_ptr: wrapping pointer counter used for both FIFO pointers.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   inc      : advance the pointer by one at the next edge
//   ptr      : current registered pointer
//   ptr_next : value the pointer takes at the next edge (ptr + inc)
// The counter wraps naturally modulo 2**PTR_W.
module fifo_ptr #(
  parameter int PTR_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] ptr_next
);

  assign ptr_next = ptr + {{(PTR_W-1){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_next;
  end

endmodule

// File: rtl/dual_ram_fifo_ctrl.sv
// dual_ram_fifo_ctrl: synchronous FIFO controller in front of a dual-port
// RAM that commits writes one edge after the request and registers its read
// address every edge.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   fifo (slave)    : push/pop valid-ready handshake
//   ram_rst_n       : RAM reset, the inverse of rst
//   ram_write_*     : RAM write port drive
//   ram_read_addr   : RAM read address (latched by the RAM each edge)
//   ram_read_data   : RAM read data, passed straight through as pop_data
//   fifo_level      : words visible to the consumer (only with FIFO_LEVEL_EN)
// Optional feature macro: FIFO_LEVEL_EN adds the fifo_level output.
module dual_ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = DEPTH_LOG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  dual_ram_fifo_ctrl_if.slave  fifo,
  output logic                 ram_rst_n,
  output logic                 ram_write_req,
  output logic [DEPTH_LOG-1:0] ram_write_addr,
  output logic [WIDTH-1:0]     ram_write_data,
  output logic [DEPTH_LOG-1:0] ram_read_addr,
  input  logic [WIDTH-1:0]     ram_read_data
`ifdef FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG:0]   fifo_level
`endif
);

  localparam int PTR_W = DEPTH_LOG + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic             push_fire;
  logic             pop_fire;
  logic             unused_wr_next;

  // Full is judged against the real write pointer so a slot is never
  // overwritten, including the head slot still being presented.
  assign fifo.push_ready = !ptr_full(ptr_t'(wr_ptr), ptr_t'(rd_ptr), DEPTH_LOG);

  // Emptiness uses the delayed write pointer: a word only becomes visible
  // once the RAM has committed it.
  assign fifo.pop_valid = !ptr_empty(ptr_t'(wr_ptr_d), ptr_t'(rd_ptr), DEPTH_LOG);

  assign push_fire = fifo.push_valid && fifo.push_ready;
  assign pop_fire  = fifo.pop_valid && fifo.pop_ready;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (push_fire),
    .ptr      (wr_ptr),
    .ptr_next (wr_ptr_next)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (pop_fire),
    .ptr      (rd_ptr),
    .ptr_next (rd_ptr_next)
  );

  // The write side only needs the registered pointer.
  assign unused_wr_next = ^wr_ptr_next;

  // Tracks the RAM's one-edge write commit so pop_valid never runs ahead of
  // the stored data.
  always_ff @(posedge clk) begin
    if (rst) wr_ptr_d <= '0;
    else     wr_ptr_d <= wr_ptr;
  end

  assign ram_rst_n      = ~rst;
  assign ram_write_req  = push_fire;
  assign ram_write_addr = wr_ptr[DEPTH_LOG-1:0];
  assign ram_write_data = fifo.push_data;

  // Presenting the next read pointer means the RAM's latched address always
  // equals the current head, so back-to-back pops see no bubble. Holding it
  // at zero during reset lines the latch up with the cleared pointer.
  assign ram_read_addr = rst ? '0 : rd_ptr_next[DEPTH_LOG-1:0];
  assign fifo.pop_data = ram_read_data;

`ifdef FIFO_LEVEL_EN
  assign fifo_level = wr_ptr_d - rd_ptr;
`endif

endmodule

// File: tb/tb_dual_ram_fifo_ctrl.sv
// Self-checking bench for dual_ram_fifo_ctrl (DEPTH_LOG=2, WIDTH=8) together
// with a behavioural model of the dual-port RAM (registered write commit,
// registered read address). Expected values come from a queue-based model of
// FIFO contents and visibility.
module tb_dual_ram_fifo_ctrl;
  localparam int WIDTH     = 8;
  localparam int DEPTH_LOG = 2;
  localparam int DEPTH     = 1 << DEPTH_LOG;

  logic                 clk;
  logic                 rst;
  logic                 ram_rst_n;
  logic                 ram_write_req;
  logic [DEPTH_LOG-1:0] ram_write_addr;
  logic [WIDTH-1:0]     ram_write_data;
  logic [DEPTH_LOG-1:0] ram_read_addr;
  logic [WIDTH-1:0]     ram_read_data;
`ifdef FIFO_LEVEL_EN
  logic [DEPTH_LOG:0]   fifo_level;
`endif

  dual_ram_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

  dual_ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo           (bus),
    .ram_rst_n      (ram_rst_n),
    .ram_write_req  (ram_write_req),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data)
`ifdef FIFO_LEVEL_EN
    ,
    .fifo_level     (fifo_level)
`endif
  );

  // RAM model: write request is registered, then committed the following
  // edge; read address is latched every edge, data read asynchronously.
  logic [WIDTH-1:0]     mem [0:DEPTH-1];
  logic                 wq_req;
  logic [DEPTH_LOG-1:0] wq_addr;
  logic [WIDTH-1:0]     wq_data;
  logic [DEPTH_LOG-1:0] rq_addr;

  always @(posedge clk) begin
    if (!ram_rst_n) begin
      wq_req <= 1'b0;
    end else begin
      wq_req  <= ram_write_req;
      wq_addr <= ram_write_addr;
      wq_data <= ram_write_data;
    end
    if (wq_req) mem[wq_addr] <= wq_data;
    rq_addr <= ram_read_addr;
  end

  assign ram_read_data = mem[rq_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] model_q[$];
  int               just_pushed;
  int               push_count;
  int               pop_count;
  int               checks;
  int               failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    just_pushed = 0;
    push_count  = 0;
    pop_count   = 0;
  endtask

  // Compares every DUT output against what the model says should be visible
  // in the current cycle with the current inputs.
  task automatic checkOutput(input logic pv, input logic [WIDTH-1:0] pd, input logic pr);
    int   vis;
    logic exp_pr;
    logic exp_pv;
    logic exp_wr;
    int   exp_pop;
    vis     = model_q.size() - just_pushed;
    exp_pr  = model_q.size() < DEPTH;
    exp_pv  = vis > 0;
    exp_wr  = pv && exp_pr;
    exp_pop = (exp_pv && pr) ? 1 : 0;
    check("push_ready", 32'(bus.push_ready), 32'(exp_pr));
    check("pop_valid", 32'(bus.pop_valid), 32'(exp_pv));
    check("ram_write_req", 32'(ram_write_req), 32'(exp_wr));
    if (exp_wr) begin
      check("ram_write_addr", 32'(ram_write_addr), 32'(push_count % DEPTH));
      check("ram_write_data", 32'(ram_write_data), 32'(pd));
    end
    if (exp_pv) check("pop_data", 32'(bus.pop_data), 32'(model_q[0]));
    check("ram_read_addr", 32'(ram_read_addr), 32'((pop_count + exp_pop) % DEPTH));
`ifdef FIFO_LEVEL_EN
    check("fifo_level", 32'(fifo_level), 32'(vis));
`endif
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling
  // edge, advance the model at the next rising edge.
  task automatic applyStimulus(input logic pv, input logic [WIDTH-1:0] pd, input logic pr);
    logic do_push;
    logic do_pop;
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = pr;
    @(negedge clk);
    checkOutput(pv, pd, pr);
    do_push = pv && (model_q.size() < DEPTH);
    do_pop  = pr && ((model_q.size() - just_pushed) > 0);
    @(posedge clk);
    if (do_pop) begin
      model_q.delete(0);
      pop_count++;
    end
    if (do_push) begin
      model_q.push_back(pd);
      push_count++;
    end
    just_pushed = do_push ? 1 : 0;
    #1;
  endtask

  task automatic applyReset(input logic pv, input logic [WIDTH-1:0] pd);
    rst            = 1'b1;
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;
    modelReset();
    @(posedge clk);
    applyReset(1'b0, 8'h00);

    // Reset state
    check("reset_push_ready", 32'(bus.push_ready), 32'd1);
    check("reset_pop_valid", 32'(bus.pop_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Single word: visible two cycles after the push
    applyStimulus(1'b1, 8'hA5, 1'b0);
    check("t1_not_visible", 32'(bus.pop_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    check("t1_visible", 32'(bus.pop_valid), 32'd1);
    check("t1_head", 32'(bus.pop_data), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Fill, rejected fifth push, bubble-free drain
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    check("t2_full", 32'(bus.push_ready), 32'd0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    check("t2_drained", 32'(bus.pop_valid), 32'd0);

    // Streaming push and pop every cycle
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Full with simultaneous pop and push: push refused that cycle
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1);
    check("t4_ready_after_pop", 32'(bus.push_ready), 32'd1);
    applyStimulus(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Pointer wrap with random stalls, head held while stalled
    begin
      int start_push = push_count;
      for (int i = 0; i < 60; i++) begin
        logic pr;
        pr = 1'($urandom_range(0, 1));
        if (bus.pop_valid && !pr) held = bus.pop_data;
        applyStimulus((push_count - start_push) < 11, 8'($urandom), pr);
      end
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    end

    // Stall stability: head must not move while pop_ready is low
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    held = 8'hC0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    check("stall_head", 32'(bus.pop_data), 32'(held));

    // Reset mid-stream with a write request in the reset cycle
    applyReset(1'b1, 8'hEE);
    check("t6_push_ready", 32'(bus.push_ready), 32'd1);
    check("t6_pop_valid", 32'(bus.pop_valid), 32'd0);
`ifdef FIFO_LEVEL_EN
    check("t6_level", 32'(fifo_level), 32'd0);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_ram_fifo_ctrl.md
Name: dual_ram_fifo_ctrl

Overview:
Synchronous FIFO controller that sequences the team's dual-port RAM model, which has a registered write path and a registered read address.
- Owns the write/read pointers, full/empty tracking and the RAM port drive.
- Presents valid/ready push and pop interfaces to the surrounding logic.
- Hides the RAM's extra write-commit cycle and its read-address latency from users.

Parameters:
WIDTH, 8, data word width; must match the RAM's WIDTH.
DEPTH_LOG, 8, log2 of FIFO depth; RAM holds 2**DEPTH_LOG words.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset; the top level drives RAM rst_n = ~rst.
push_valid  input  1  push request.
push_data  input  WIDTH  push word.
push_ready  output  1  FIFO can accept a word; high when not full.
pop_valid  output  1  pop_data holds the FIFO head.
pop_data  output  WIDTH  head word; wired directly from ram_read_data.
pop_ready  input  1  consumer takes the head.
ram_write_req  output  1  to RAM write request.
ram_write_addr  output  DEPTH_LOG  to RAM write address.
ram_write_data  output  WIDTH  to RAM write data.
ram_read_addr  output  DEPTH_LOG  to RAM read address; the RAM latches it every edge.
ram_read_data  input  WIDTH  from RAM.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high on rst.
- Pointers: wr_ptr and rd_ptr are DEPTH_LOG+1 bits; the low DEPTH_LOG bits address the RAM, the MSB is the wrap bit; both wrap mod 2**(DEPTH_LOG+1).
- Visible write pointer: wr_ptr_d is wr_ptr registered one cycle, because the RAM commits a write one edge after the request.
- Push: accepted when push_valid && push_ready. In that same cycle, drive ram_write_req=1, ram_write_addr=wr_ptr[low], ram_write_data=push_data; wr_ptr increments at the edge. Otherwise ram_write_req=0.
- Full: push_ready = !((wr_ptr ^ rd_ptr) == {1'b1, 0...}), computed against the real wr_ptr. A push while full is ignored: no RAM write, no pointer change.
- Empty: pop_valid = (rd_ptr != wr_ptr_d).
- Read address drive:
  - ram_read_addr = rd_ptr_next[low], where rd_ptr_next = rd_ptr + (pop_valid && pop_ready).
  - The RAM's latched read address therefore always equals rd_ptr[low], so pop_data is the current head with no bubble between consecutive pops.
- Latency:
  - Push accepted at edge t → pop_valid high in the cycle after edge t+1 (2-cycle push-to-visible).
  - Pop → new head valid in the next cycle.
- Throughput: one push and one pop per cycle, sustained.
- Simultaneous push and pop:
  - Both take effect.
  - When full, a pop frees a slot at the edge; push_ready rises the following cycle (no same-cycle pass-through).
  - When visibly empty, a push does not make pop_valid high early.
- Pop while pop_valid=0 is ignored.
- Head stability: pop_data is stable while pop_valid && !pop_ready. The head slot cannot be rewritten until it is popped.
- Reset values: wr_ptr=0, wr_ptr_d=0, rd_ptr=0; push_ready=1, pop_valid=0, ram_write_req=0, ram_read_addr=0.
- Reset mid-operation: all contents are discarded; a write request issued the same cycle as rst is dropped by the RAM reset. pop_valid is low in the first cycle after reset.
- RAM contents are not cleared by reset, and there is no visibility into them.

Optional Feature:
FIFO_LEVEL_EN
- Defined: adds output fifo_level [DEPTH_LOG:0] = wr_ptr_d - rd_ptr, the count of words visible to the consumer; 0 after reset, 2**DEPTH_LOG when full and fully committed.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `fifo_pkg`:
  - localparam PTR_W = DEPTH_LOG+1.
  - ptr_t typedef.
  - Functions ptr_full(wr, rd) and ptr_empty(wr, rd).
- One natural sub-module, fifo_ptr: a parameterized wrapping pointer counter with an inc input and a next-value output, instantiated twice (write and read).
- Bench top instantiates dual_ram_fifo_ctrl plus the RAM model.

Test Plan:
1. Single word, DEPTH_LOG=2: push 0xA5 at cycle 0 → pop_valid=0 in cycles 0-1, pop_valid=1 with pop_data=0xA5 at cycle 2; pop → pop_valid=0 next cycle.
2. Fill: push 0x01..0x04 back-to-back with pop_ready=0 → push_ready=0 after the 4th push; a 5th push of 0x05 is ignored (no ram_write_req); draining yields 0x01,0x02,0x03,0x04 with no bubbles.
3. Streaming: push_valid=1 and pop_ready=1 every cycle for 20 cycles with data 0..19 → output sequence 0..19 in order, 1 word per cycle after the 2-cycle startup, push_ready never drops.
4. Full plus simultaneous push/pop: at full, pop_ready=1 and push 0x55 in the same cycle → the push is rejected that cycle; push_ready=1 the next cycle; 0x55 is later popped after the remaining 3 words.
5. Pointer wrap: push/pop 11 words, more than 2x depth, with random pop_ready stalls → data order preserved; pop_data stable during stalls.
6. Reset mid-stream: assert rst for 1 cycle with 3 words queued → push_ready=1, pop_valid=0, ram_write_req=0 next cycle; FIFO_LEVEL_EN build shows fifo_level=0.
